// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt front-end.
// Priority helper: lowest set index wins.
package interrupt_pkg;

    localparam int NUM_IRQ  = 8;
    localparam int ID_W     = 3;
    localparam int STATUS_W = 9;

    localparam logic [15:0] DEFAULT_VECTOR_BASE = 16'h0010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_VECTOR,
        ST_SERVICE,
        ST_RESTORE
    } irq_state_t;

    function automatic logic [ID_W-1:0] lowest_set(input logic [NUM_IRQ-1:0] vec);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) id = ID_W'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous irq line, followed by a
// previous-value flop so a rising edge yields a single-cycle strobe.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt front-end: pending/mask/gie bookkeeping, priority select and the
// save/vector/service/restore sequence feeding the register file.
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter logic [15:0] VECTOR_BASE = DEFAULT_VECTOR_BASE,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic [8:0]          ctrl_input,
    input  logic                ctrl_write,
    input  logic                instr_boundary,
    input  logic [15:0]         pc_input,
    input  logic                vector_ack,
    input  logic                reti,
    output logic                vector_valid,
    output logic [15:0]         vector_address,
    output logic                r_backup,
    output logic                r_restore,
    output logic [15:0]         return_address_input,
    output logic                return_address_write,
    output logic [STATUS_W-1:0] interrupt_input,
    output logic                interrupt_write
);

    logic [NUM_IRQ-1:0] irq_edge;

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .irq_in   (irq[gi]),
            .edge_out (irq_edge[gi])
        );
    end

    irq_state_t          state_q, state_d;
    logic [NUM_IRQ-1:0]  pending_q, pending_d, pending_clr;
    logic [NUM_IRQ-1:0]  mask_q, mask_d;
    logic                gie_q, gie_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [NUM_IRQ-1:0]  eligible;
    logic [ID_W-1:0]     sel_id;
    logic [STATUS_W-1:0] status;

    logic                vector_valid_q, vector_valid_d;
    logic [15:0]         vector_address_q, vector_address_d;
    logic                r_backup_q, r_backup_d;
    logic                r_restore_q, r_restore_d;
    logic [15:0]         ret_addr_q, ret_addr_d;
    logic                ret_write_q, ret_write_d;
    logic [STATUS_W-1:0] int_input_q, int_input_d;
    logic                int_write_q, int_write_d;

    assign eligible = pending_q & mask_q;
    assign sel_id   = lowest_set(eligible);
    assign status   = {state_q == ST_SERVICE, pending_q};

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        mask_d      = mask_q;
        gie_d       = gie_q;
        pending_clr = '0;

        if (ctrl_write) begin
            mask_d = ctrl_input[7:0];
            if (state_q == ST_IDLE) gie_d = ctrl_input[8];
        end

        case (state_q)
            ST_IDLE: begin
                if (gie_q && (|eligible) && instr_boundary) begin
                    state_d     = ST_SAVE;
                    id_d        = sel_id;
                    pending_clr = NUM_IRQ'(1) << sel_id;
                    gie_d       = 1'b0;
                end
            end
            ST_SAVE:    state_d = ST_VECTOR;
            ST_VECTOR:  if (vector_ack) state_d = ST_SERVICE;
            ST_SERVICE: if (reti) state_d = ST_RESTORE;
            ST_RESTORE: begin
                state_d = ST_IDLE;
                gie_d   = 1'b1;
            end
            default:    state_d = ST_IDLE;
        endcase

        // A fresh edge on the line being acknowledged must not be lost.
        pending_d = (pending_q & ~pending_clr) | irq_edge;
    end

    // Outputs are decoded from the next state so pulses line up with the state.
    always_comb begin
        r_backup_d       = (state_d == ST_SAVE);
        ret_write_d      = (state_d == ST_SAVE);
        ret_addr_d       = (state_d == ST_SAVE) ? pc_input : ret_addr_q;
        vector_valid_d   = (state_d == ST_VECTOR);
        vector_address_d = (state_d == ST_VECTOR) ? (VECTOR_BASE + 16'({id_d, 2'b00})) : '0;
        r_restore_d      = (state_d == ST_RESTORE);
        int_input_d      = status;
        int_write_d      = (status != int_input_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            pending_q        <= '0;
            mask_q           <= '0;
            gie_q            <= 1'b0;
            id_q             <= '0;
            vector_valid_q   <= 1'b0;
            vector_address_q <= '0;
            r_backup_q       <= 1'b0;
            r_restore_q      <= 1'b0;
            ret_addr_q       <= '0;
            ret_write_q      <= 1'b0;
            int_input_q      <= '0;
            int_write_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            mask_q           <= mask_d;
            gie_q            <= gie_d;
            id_q             <= id_d;
            vector_valid_q   <= vector_valid_d;
            vector_address_q <= vector_address_d;
            r_backup_q       <= r_backup_d;
            r_restore_q      <= r_restore_d;
            ret_addr_q       <= ret_addr_d;
            ret_write_q      <= ret_write_d;
            int_input_q      <= int_input_d;
            int_write_q      <= int_write_d;
        end
    end

    assign vector_valid         = vector_valid_q;
    assign vector_address       = vector_address_q;
    assign r_backup             = r_backup_q;
    assign r_restore            = r_restore_q;
    assign return_address_input = ret_addr_q;
    assign return_address_write = ret_write_q;
    assign interrupt_input      = int_input_q;
    assign interrupt_write      = int_write_q;

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt front-end for the 16-bit processor, directly upstream of `Register_File`. It synchronises eight external interrupt lines, latches rising edges as pending, applies mask and global enable, and runs a save/vector/service/restore sequence. It produces the `interrupt_input`/`interrupt_write`, `r_backup`/`r_restore` and `return_address_input`/`return_address_write` controls that the register file consumes.

## Interface
- `VECTOR_BASE`, 16'h0010: address of vector 0; vector n = `VECTOR_BASE + 4*n`.
- `SYNC_STAGES`, 2: synchroniser depth per irq line (≥2).

- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `irq` in 8: asynchronous interrupt requests; rising edge = request.
- `ctrl_input` in 9: {gie, mask[7:0]} written by CPU.
- `ctrl_write` in 1: load `ctrl_input`.
- `instr_boundary` in 1: CPU is between instructions; entry is allowed only here.
- `pc_input` in 16: PC to save as return address.
- `vector_ack` in 1: CPU accepted `vector_address`.
- `reti` in 1: return-from-interrupt executed.
- `vector_valid` out 1: vector address offered.
- `vector_address` out 16: handler address.
- `r_backup` out 1: one-cycle pulse to register file.
- `r_restore` out 1: one-cycle pulse to register file.
- `return_address_input` out 16: saved PC.
- `return_address_write` out 1: one-cycle pulse.
- `interrupt_input` out 9: status word {in_service, pending[7:0]}.
- `interrupt_write` out 1: one-cycle pulse when the status word changes.

## Operation
- Per line: `SYNC_STAGES` flops, then a previous-value flop. `edge = sync_last & ~prev` sets `pending[n]` on the next edge.
- `eligible = pending & mask`. The selected id is the lowest set index, so index 0 has the highest priority.
- FSM states: IDLE, SAVE, VECTOR, SERVICE, RESTORE.
  - IDLE → SAVE when `gie & |eligible & instr_boundary`. On that edge, latch the id, clear `pending[id]` and clear `gie`.
  - SAVE, one cycle: `r_backup=1`, `return_address_write=1`, `return_address_input=pc_input` (registered). Then → VECTOR.
  - VECTOR: `vector_valid=1`, `vector_address = VECTOR_BASE + {id,2'b00}`. Held until `vector_ack` is sampled high, then → SERVICE.
  - SERVICE: `in_service=1`. When `reti` is sampled high → RESTORE.
  - RESTORE, one cycle: `r_restore=1`, set `gie=1`. Then → IDLE.
- `ctrl_write` always updates `mask`. Its `gie` bit is honoured only in IDLE; it is ignored in every other state.
- If a new edge on `pending[id]` coincides with the clear at IDLE→SAVE, the set wins and the bit stays pending.
- No nesting: other pending bits wait until the FSM returns to IDLE.
- `interrupt_write` pulses the cycle after `{in_service, pending}` changes; `interrupt_input` carries the new value.
- `reti` outside SERVICE and `vector_ack` outside VECTOR are ignored.

## Timing
- Reset values:
  - State IDLE; `pending`, `mask`, `gie` all 0; synchronisers 0.
  - All outputs 0, including `vector_address` and `return_address_input`.
- All outputs are registered. They are stable across the falling edge, where `Register_File` samples them.
- Latency from `irq` rising edge (set-up before edge e0, default depth) to visible pending:
  - `sync_last` high after e1.
  - `pending` set at e2.
  - `interrupt_write` at e3.
- Entry sequence, given gie, mask and boundary true:
  - SAVE pulses in the cycle after e3.
  - `vector_valid` one cycle later.
- Minimum period from `vector_ack` to RESTORE is 2 cycles.
- `rst_n` low mid-sequence aborts immediately to reset values; no restore pulse is emitted.

## Structure
- Package `interrupt_pkg`:
  - State enum `irq_state_t`.
  - `NUM_IRQ=8`, `ID_W=3`, `STATUS_W=9`.
  - Default `VECTOR_BASE`.
- Sub-module `irq_sync_edge`: one line's synchroniser and rising-edge detect, with parameter `SYNC_STAGES`. Instantiated 8 times.
- Priority encoder and FSM live in `interrupt_controller`.

## Test plan
- Reset, then `ctrl_write` with 9'h1FF. Pulse `irq[3]` with `instr_boundary=1`, CPU PC 16'h0123 → `return_address_input`=16'h0123 with a write pulse; `r_backup` pulse; `vector_address`=16'h001C.
- `irq[5]` and `irq[2]` rise in the same cycle → vector 16'h0018 taken first. After `reti`/RESTORE, vector 16'h0024 follows.
- `mask`=8'hFE, pulse `irq[0]` → `pending[0]`=1 and `interrupt_input`=9'h001, but no SAVE. Then write mask 8'hFF → entry occurs.
- In SERVICE, pulse `irq[1]` and write `gie`=1 → no re-entry. `reti` → `r_restore` pulse, then entry to vector 16'h0014.
- Hold `vector_ack` low for 5 cycles → `vector_valid` and address stay constant. Assert `rst_n` low in VECTOR → all outputs 0 immediately; no `r_restore`.
